ps2_rx: RTL and testbench



---
 rtl/ps2_pkg.sv | 18 +
 rtl/ps2_filter.sv | 40 ++++
 rtl/ps2_rx.sv | 118 +++++++++++
 tb/tb_ps2_rx.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 device-to-host receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int unsigned DATA_BITS   = 8;
  localparam logic        START_LEVEL = 1'b0;
  localparam logic        STOP_LEVEL  = 1'b1;

  localparam int unsigned DEF_FILTER_LEN = 8;
  localparam int unsigned DEF_TIMEOUT    = 100000;

endpackage

// File: rtl/ps2_filter.sv
// Two-flop synchroniser followed by a counter glitch filter for one PS/2 pin.
module ps2_filter
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN = DEF_FILTER_LEN
) (
  input  logic clock,
  input  logic resetn,
  input  logic din,
  output logic level
);

  localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // cnt holds how many consecutive opposite samples precede the current one,
  // so the level flips on the FILTER_LEN-th and the counter can never wrap.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync  <= '1;
      cnt   <= '0;
      level <= 1'b1;
    end else begin
      sync <= {sync[0], din};
      if (sync[1] != level) begin
        if (cnt >= CW'(FILTER_LEN - 1)) begin
          level <= sync[1];
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: filters the pins, deserialises 11-bit frames.
// Define PS2_PARITY_CHECK_EN to reject frames failing odd parity.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN = DEF_FILTER_LEN,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] ps2_data,
  output logic       ps2_hit,
  output logic       ps2_err
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic          clk_f;
  logic          dat_f;
  logic          clk_prev;
  logic          fall;
  logic          expire;
  logic          parity_ok;
  logic          hit_next;
  logic          err_next;
  state_t        state;
  state_t        state_next;
  logic [2:0]    bitcnt;
  logic [7:0]    shreg;
  logic [TW-1:0] tcnt;

  ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clock  (clock),
    .resetn (resetn),
    .din    (ps2_clk),
    .level  (clk_f)
  );

  ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filter (
    .clock  (clock),
    .resetn (resetn),
    .din    (ps2_dat),
    .level  (dat_f)
  );

  assign fall = clk_prev & ~clk_f;
  // A fall in the expiry cycle wins over the timeout.
  assign expire = (state != IDLE) && (tcnt == TW'(TIMEOUT - 1)) && !fall;

`ifdef PS2_PARITY_CHECK_EN
  logic par_bit;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)                      par_bit <= 1'b0;
    else if (fall && state == PARITY) par_bit <= dat_f;
  end

  assign parity_ok = ^{shreg, par_bit};
`else
  assign parity_ok = 1'b1;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (fall) begin
      unique case (state)
        IDLE:   if (dat_f == START_LEVEL) state_next = DATA;
        DATA:   if (bitcnt == 3'(DATA_BITS - 1)) state_next = PARITY;
        PARITY: state_next = STOP;
        STOP:   state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end else if (expire) begin
      state_next = IDLE;
    end
  end

  always_comb begin
    hit_next = 1'b0;
    err_next = expire;
    if (fall && state == STOP) begin
      if (dat_f == STOP_LEVEL && parity_ok) hit_next = 1'b1;
      else                                  err_next = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      clk_prev <= 1'b1;
      tcnt     <= '0;
      bitcnt   <= '0;
      shreg    <= '0;
      ps2_data <= '0;
      ps2_hit  <= 1'b0;
      ps2_err  <= 1'b0;
    end else begin
      clk_prev <= clk_f;
      ps2_hit  <= hit_next;
      ps2_err  <= err_next;
      if (fall || state == IDLE) tcnt <= '0;
      else if (tcnt != '1)       tcnt <= tcnt + 1'b1;
      if (fall && state == IDLE) bitcnt <= '0;
      else if (fall && state == DATA) begin
        bitcnt <= bitcnt + 1'b1;
        shreg  <= {dat_f, shreg[7:1]};
      end
      if (hit_next) ps2_data <= shreg;
    end
  end

endmodule

// File: tb/tb_ps2_rx.sv
// Randomised bench for ps2_rx against a frame-level model of expected outcomes.
module tb_ps2_rx;

  localparam int unsigned FL   = 8;
  localparam int unsigned TO   = 400;
  localparam int unsigned HALF = 30;

  logic       clock   = 1'b0;
  logic       resetn  = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [7:0] ps2_data;
  logic       ps2_hit;
  logic       ps2_err;

  ps2_rx #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .ps2_clk  (ps2_clk),
    .ps2_dat  (ps2_dat),
    .ps2_data (ps2_data),
    .ps2_hit  (ps2_hit),
    .ps2_err  (ps2_err)
  );

  always #10 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;

  int hits = 0, errs = 0, both = 0, wide = 0, unstable = 0;
  logic       prev_hit = 1'b0, prev_err = 1'b0;
  logic [7:0] prev_data = '0;
  logic [7:0] model_data = '0;

  always @(negedge clock) begin
    if (ps2_hit) hits++;
    if (ps2_err) errs++;
    if (ps2_hit && ps2_err) both++;
    if ((ps2_hit && prev_hit) || (ps2_err && prev_err)) wide++;
    if (resetn && !ps2_hit && ps2_data !== prev_data) unstable++;
    prev_hit  = ps2_hit;
    prev_err  = ps2_err;
    prev_data = ps2_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Device drives data while the clock is high; the host samples on the fall.
  task automatic send_bits(input logic [10:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = bits[i];
      wait_cyc(HALF);
      ps2_clk = 1'b0;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] b, input logic bad_par,
                                             input logic stop);
    logic par;
    par = ~(^b) ^ bad_par;
    return {stop, par, b, 1'b0};
  endfunction

  task automatic run_frame(input string tag, input logic [7:0] b, input logic bad_par,
                           input logic stop);
    int   h0, e0;
    logic accept;
    h0 = hits;
    e0 = errs;
    send_bits(make_frame(b, bad_par, stop), 11);
`ifdef PS2_PARITY_CHECK_EN
    accept = stop && !bad_par;
`else
    accept = stop;
`endif
    if (accept) model_data = b;
    check({tag, "_hit"}, hits - h0, {31'd0, accept});
    check({tag, "_err"}, errs - e0, {31'd0, !accept});
    check({tag, "_data"}, ps2_data, model_data);
  endtask

  initial begin
    int h0, e0, c, elapsed;
    wait_cyc(5);
    check("rst_data", ps2_data, 0);
    check("rst_hit", ps2_hit, 0);
    check("rst_err", ps2_err, 0);
    resetn = 1'b1;
    wait_cyc(20);

    run_frame("f1c", 8'h1C, 1'b0, 1'b1);
    run_frame("b2b_f0", 8'hF0, 1'b0, 1'b1);
    run_frame("b2b_1c", 8'h1C, 1'b0, 1'b1);
    wait_cyc(50);
    run_frame("badpar_5a", 8'h5A, 1'b1, 1'b1);
    wait_cyc(50);
    run_frame("badstop_23", 8'h23, 1'b0, 1'b0);
    wait_cyc(50);

    // Partial frame then silence: error must fire a fixed delay after the last pin fall.
    h0 = hits;
    e0 = errs;
    send_bits(make_frame(8'hA7, 1'b0, 1'b1), 5);
    c = 0;
    while (errs == e0 && c < int'(TO + FL) + 40) begin
      wait_cyc(1);
      c++;
    end
    elapsed = int'(HALF) + c;
    check("to_err", errs - e0, 1);
    check("to_hit", hits - h0, 0);
    check("to_when", (elapsed >= int'(TO + FL) + 2) && (elapsed <= int'(TO + FL) + 4), 1);
    wait_cyc(20);
    run_frame("after_to_76", 8'h76, 1'b0, 1'b1);
    wait_cyc(50);

    // Short clock glitch with data low would look like a start bit if not filtered.
    h0 = hits;
    e0 = errs;
    ps2_dat = 1'b0;
    ps2_clk = 1'b0;
    wait_cyc(FL - 2);
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    wait_cyc(40);
    check("glitch_hit", hits - h0, 0);
    check("glitch_err", errs - e0, 0);
    run_frame("after_glitch_3a", 8'h3A, 1'b0, 1'b1);
    wait_cyc(50);

    // Reset in the middle of a frame.
    e0 = errs;
    h0 = hits;
    send_bits(make_frame(8'h55, 1'b0, 1'b1), 6);
    resetn = 1'b0;
    wait_cyc(3);
    model_data = '0;
    check("midrst_data", ps2_data, 0);
    check("midrst_hit", ps2_hit, 0);
    check("midrst_err", ps2_err, 0);
    resetn = 1'b1;
    wait_cyc(30);
    check("midrst_no_err", errs - e0, 0);
    check("midrst_no_hit", hits - h0, 0);
    run_frame("after_rst_29", 8'h29, 1'b0, 1'b1);

    for (int i = 0; i < 24; i++) begin
      logic [7:0] b;
      logic       bp, st;
      b  = 8'($urandom);
      bp = ($urandom_range(0, 3) == 0);
      st = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 1) == 1) wait_cyc(int'($urandom_range(0, 100)));
      run_frame($sformatf("rnd%0d", i), b, bp, st);
    end
    wait_cyc(50);

    check("hit_err_overlap", both, 0);
    check("pulse_width", wide, 0);
    check("data_stable", unstable, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #(20 * 200000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
